sram_master: RTL and testbench
==============================

// Module: sram_master
// PURPOSE
//  Initiator for the single-port sync SRAM (ce/we/addr/data, 1-cycle read, o_data tristated when not reading).
//  Accepts read/write burst commands from CPU-side logic via valid/ready.
//  Drives the SRAM pins, streams write data in, returns read data as a response stream.
//  Sits between the CPU datapath/DMA and the sram instance.
// PARAMETERS
//  ADDR_WIDTH  12  SRAM address width; burst addresses wrap mod 2**ADDR_WIDTH
//  WORD_WIDTH  16  SRAM data width
//  LEN_WIDTH   4   burst length field; beats = i_req_len+1 (1..2**LEN_WIDTH)
// PORTS
//  clk           in   1   single clock, all state on posedge
//  rst_n         in   1   asynchronous, active-low reset
//  i_req_valid   in   1   command valid
//  o_req_ready   out  1   command accepted when valid&ready; high only in IDLE
//  i_req_we      in   1   1=write burst, 0=read burst
//  i_req_addr    in   ADDR_WIDTH  start address
//  i_req_len     in   LEN_WIDTH   beats-1
//  i_wdata_valid in   1   write beat valid
//  o_wdata_ready out  1   write beat accepted when valid&ready
//  i_wdata       in   WORD_WIDTH  write beat data
//  o_rsp_valid   out  1   read beat valid, 1-cycle pulse per beat, no backpressure
//  o_rsp_data    out  WORD_WIDTH  read beat data, held until next beat
//  o_done        out  1   1-cycle pulse on last write beat / with last read beat
//  o_mem_ce      out  1   SRAM chip enable
//  o_mem_we      out  1   SRAM write enable
//  o_mem_addr    out  ADDR_WIDTH  SRAM address
//  o_mem_wdata   out  WORD_WIDTH  SRAM write data
//  i_mem_rdata   in   WORD_WIDTH  SRAM o_data (Z outside read cycles; never sampled then)
// BEHAVIOUR
//  Reset: state IDLE; o_mem_ce/we=0, o_mem_addr=0, o_rsp_valid=0, o_rsp_data=0, o_done=0,
//   o_wdata_ready=0; o_req_ready=1 once rst_n deasserts. Reset mid-burst aborts at once (ce drops
//   asynchronously); no o_done, no further o_rsp_valid.
//  FSM: IDLE -> WRITE (accept, we=1) | READ (accept, we=0); WRITE -> IDLE after last beat;
//   READ -> DRAIN after last address issued; DRAIN -> IDLE after 1 cycle.
//  Internal regs: addr (current), beats_left (i_req_len on accept); both decrement/increment per beat.
//  WRITE: o_wdata_ready=1. o_mem_ce=o_mem_we=i_wdata_valid, o_mem_wdata=i_wdata, o_mem_addr=addr
//   (write-side controls combinational from i_wdata_valid). No valid -> ce=0, no access, burst stalls.
//  READ: registered ce=1, we=0, addr=start..start+len, one address per cycle, no stalls.
//  DRAIN: ce=1, we=0, addr held at last address so SRAM keeps driving o_data.
//  Read capture: rd_pend=1 in the cycle after each READ issue cycle. i_mem_rdata is registered into
//   o_rsp_data on that cycle's closing edge; o_rsp_valid=1 for the following cycle.
//  Read latency: accept edge -> o_rsp_valid high 2 cycles later (beat 0).
//   N-beat read busy N+1 cycles, then IDLE.
//  Address increment wraps: (2**ADDR_WIDTH-1)+1 -> 0, burst continues.
//  Len=0: single beat; READ is 1 cycle then DRAIN.
//  Back-to-back: new command accepted in the first IDLE cycle; no overlap with DRAIN.
//  o_done: write -> same cycle as last beat handshake (combinational with valid&ready&last);
//   read -> same cycle as last o_rsp_valid.
// CONFIGURATION
//  SRAM_MASTER_RSP_REG_EN defined: extra output register on o_rsp_valid/o_rsp_data/read o_done;
//   read latency 3 cycles; FSM still returns to IDLE after N+1 cycles.
//   A read accepted then has its first o_rsp_valid no earlier than the previous burst's last one.
//  Not defined: latency 2, as above.
// STRUCTURE
//  Shared header sram_defs.vh: state encodings (ST_IDLE/ST_WRITE/ST_READ/ST_DRAIN, 2 bits),
//   default ADDR_WIDTH/WORD_WIDTH, shared with sram.
//  One sub-module: sram_burst_cnt (load start addr/len, step, wrapping addr, last flag).
//  FSM, write mux and read capture stay in sram_master.
// TESTING (bench instantiates sram as the responder)
//  1. Write addr=0x010 len=3, data 0xA0A0..0xA0A3 every cycle -> 4 SRAM writes at 0x010..0x013,
//     o_done on 4th beat.
//  2. Read addr=0x010 len=3 -> o_rsp_data 0xA0A0..0xA0A3 on 4 consecutive cycles starting 2 cycles
//     after accept; o_done with 4th; o_req_ready back after 5 cycles.
//  3. Write len=2 with i_wdata_valid low on cycle 2 -> o_mem_ce=0 that cycle, burst completes one
//     cycle later, memory contents correct.
//  4. Read addr=0xFFE len=3 -> addresses 0xFFE,0xFFF,0x000,0x001; data matches preloaded words.
//  5. rst_n low during READ beat 2 -> o_mem_ce=0 immediately, no further o_rsp_valid/o_done;
//     after release o_req_ready=1, next read correct.
//  6. Rerun tests 1-5 with SRAM_MASTER_RSP_REG_EN -> same data, read responses shifted +1 cycle.

Source files
------------

// File: rtl/sram_master_pkg.sv
// Shared types and defaults for the SRAM burst master.
package sram_master_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 12;
    localparam int unsigned DEF_WORD_WIDTH = 16;
    localparam int unsigned DEF_LEN_WIDTH  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/sram_master_burst_cnt.sv
// Burst address/beat counter: load start address and length, step per beat, wrap address.
module sram_burst_cnt #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last_c
);

    logic [LEN_WIDTH-1:0] beats_left;

    // Address increments modulo 2**ADDR_WIDTH through natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr       <= '0;
            beats_left <= '0;
        end else if (load) begin
            addr       <= start_addr;
            beats_left <= len;
        end else if (step) begin
            addr       <= addr + ADDR_WIDTH'(1);
            beats_left <= beats_left - LEN_WIDTH'(1);
        end
    end

    assign last_c = (beats_left == '0);

endmodule

// File: rtl/sram_master.sv
// Burst initiator for a single-port synchronous SRAM (1-cycle read latency).
// Define SRAM_MASTER_RSP_REG_EN to add one output register stage on the read response.
module sram_master
    import sram_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [LEN_WIDTH-1:0]  i_req_len,
    input  logic                  i_wdata_valid,
    output logic                  o_wdata_ready,
    input  logic [WORD_WIDTH-1:0] i_wdata,
    output logic                  o_rsp_valid,
    output logic [WORD_WIDTH-1:0] o_rsp_data,
    output logic                  o_done,
    output logic                  o_mem_ce,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [WORD_WIDTH-1:0] o_mem_wdata,
    input  logic [WORD_WIDTH-1:0] i_mem_rdata
);

    state_t state, state_nxt;

    logic                  accept;
    logic                  wr_hs;
    logic                  rd_issue;
    logic                  step;
    logic                  last_c;
    logic [ADDR_WIDTH-1:0] cnt_addr;

    logic                  rd_pend;
    logic                  rd_last_pend;
    logic                  cap_valid;
    logic                  cap_done;
    logic [WORD_WIDTH-1:0] cap_data;

    assign accept   = i_req_valid && o_req_ready;
    assign wr_hs    = (state == ST_WRITE) && i_wdata_valid;
    assign rd_issue = (state == ST_READ);
    // Hold the address on the last beat so DRAIN keeps reading the final word.
    assign step     = (wr_hs || rd_issue) && !last_c;

    sram_burst_cnt #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept),
        .start_addr (i_req_addr),
        .len        (i_req_len),
        .step       (step),
        .addr       (cnt_addr),
        .last_c     (last_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = i_req_we ? ST_WRITE : ST_READ;
            ST_WRITE: if (wr_hs && last_c) state_nxt = ST_IDLE;
            ST_READ:  if (last_c) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Read controls come straight off the state register; write controls follow i_wdata_valid.
    assign o_req_ready   = (state == ST_IDLE) && rst_n;
    assign o_wdata_ready = (state == ST_WRITE);
    assign o_mem_ce      = wr_hs || (state == ST_READ) || (state == ST_DRAIN);
    assign o_mem_we      = wr_hs;
    assign o_mem_addr    = cnt_addr;
    assign o_mem_wdata   = wr_hs ? i_wdata : '0;

    // rd_pend marks the cycle in which the SRAM presents the word addressed one cycle earlier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend      <= 1'b0;
            rd_last_pend <= 1'b0;
            cap_valid    <= 1'b0;
            cap_done     <= 1'b0;
            cap_data     <= '0;
        end else begin
            rd_pend      <= rd_issue;
            rd_last_pend <= rd_issue && last_c;
            cap_valid    <= rd_pend;
            cap_done     <= rd_last_pend;
            if (rd_pend) cap_data <= i_mem_rdata;
        end
    end

`ifdef SRAM_MASTER_RSP_REG_EN
    logic                  out_valid;
    logic                  out_done;
    logic [WORD_WIDTH-1:0] out_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_done  <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= cap_valid;
            out_done  <= cap_done;
            if (cap_valid) out_data <= cap_data;
        end
    end

    assign o_rsp_valid = out_valid;
    assign o_rsp_data  = out_data;
    assign o_done      = (wr_hs && last_c) || out_done;
`else
    assign o_rsp_valid = cap_valid;
    assign o_rsp_data  = cap_data;
    assign o_done      = (wr_hs && last_c) || cap_done;
`endif

endmodule

// File: tb/tb_sram_master.sv
// Directed bench for sram_master with a behavioural 1-cycle-read SRAM responder.
module tb_sram_master;

    localparam int unsigned AW = 12;
    localparam int unsigned WW = 16;
    localparam int unsigned LW = 4;
`ifdef SRAM_MASTER_RSP_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_len = '0;
    logic          wdata_valid = 1'b0;
    logic          wdata_ready;
    logic [WW-1:0] wdata = '0;
    logic          rsp_valid;
    logic [WW-1:0] rsp_data;
    logic          done;
    logic          mem_ce;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_wdata;
    logic [WW-1:0] mem_rdata;

    logic [WW-1:0] sram    [4096];
    logic [WW-1:0] exp_mem [4096];
    logic [WW-1:0] rd_q = '0;
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [WW-1:0] pre_data = '0;

    int tests = 0;
    int fails = 0;

    sram_master dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_we      (req_we),
        .i_req_addr    (req_addr),
        .i_req_len     (req_len),
        .i_wdata_valid (wdata_valid),
        .o_wdata_ready (wdata_ready),
        .i_wdata       (wdata),
        .o_rsp_valid   (rsp_valid),
        .o_rsp_data    (rsp_data),
        .o_done        (done),
        .o_mem_ce      (mem_ce),
        .o_mem_we      (mem_we),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .i_mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM responder: synchronous write, registered read data.
    always @(posedge clk) begin
        if (pre_en) sram[pre_addr] <= pre_data;
        else if (mem_ce) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        rd_q <= sram[mem_addr];
        end
    end
    assign mem_rdata = rd_q;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [WW-1:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        exp_mem[a] = d;
        cycle();
        pre_en = 1'b0;
    endtask

    task automatic send_req(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] l);
        req_valid = 1'b1; req_we = we; req_addr = a; req_len = l;
        #1;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        cycle();
        req_valid = 1'b0;
    endtask

    // Write burst; vmask bit c gives i_wdata_valid for the c-th cycle after accept.
    task automatic run_write(input logic [AW-1:0] a, input logic [LW-1:0] l,
                             input logic [WW-1:0] base, input logic [7:0] vmask, input int ncyc);
        int beat = 0;
        int n = int'(l) + 1;
        logic [AW-1:0] ba;
        send_req(1'b1, a, l);
        for (int c = 0; c < ncyc; c++) begin
            wdata_valid = vmask[c];
            wdata = base + WW'(beat);
            ba = a + AW'(beat);
            #1;
            chk("wr_wdata_ready", 32'(wdata_ready), 32'd1);
            chk("wr_ce", 32'(mem_ce), 32'(vmask[c]));
            chk("wr_done", 32'(done), 32'(vmask[c] && beat == n - 1));
            if (vmask[c]) begin
                chk("wr_we", 32'(mem_we), 32'd1);
                chk("wr_addr", 32'(mem_addr), 32'(ba));
                chk("wr_data", 32'(mem_wdata), 32'(wdata));
                exp_mem[ba] = wdata;
                beat++;
            end
            cycle();
        end
        wdata_valid = 1'b0;
        #1;
        chk("wr_end_ready", 32'(req_ready), 32'd1);
        chk("wr_end_ce", 32'(mem_ce), 32'd0);
        for (int i = 0; i < n; i++)
            chk("wr_mem", 32'(sram[a + AW'(i)]), 32'(exp_mem[a + AW'(i)]));
    endtask

    task automatic run_read(input logic [AW-1:0] a, input logic [LW-1:0] l);
        int n = int'(l) + 1;
        int k;
        logic rv;
        logic [AW-1:0] ea;
        send_req(1'b0, a, l);
        for (int t = 1; t <= n + LAT + 1; t++) begin
            ea = (t <= n) ? a + AW'(t - 1) : a + AW'(n - 1);
            chk("rd_ce", 32'(mem_ce), 32'(t <= n + 1));
            if (t <= n + 1) begin
                chk("rd_we", 32'(mem_we), 32'd0);
                chk("rd_addr", 32'(mem_addr), 32'(ea));
            end
            k = t - LAT - 1;
            rv = (k >= 0) && (k < n);
            chk("rd_rsp_valid", 32'(rsp_valid), 32'(rv));
            chk("rd_done", 32'(done), 32'(rv && k == n - 1));
            if (rv) chk("rd_rsp_data", 32'(rsp_data), 32'(exp_mem[a + AW'(k)]));
            chk("rd_req_ready", 32'(req_ready), 32'(t >= n + 2));
            cycle();
        end
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_ce", 32'(mem_ce), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wdata_ready", 32'(wdata_ready), 32'd0);
        cycle();
        cycle();
        rst_n = 1'b1;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        cycle();

        // 1: four-beat write, data every cycle
        run_write(12'h010, 4'd3, 16'hA0A0, 8'b0000_1111, 4);
        // 2: read it back
        run_read(12'h010, 4'd3);
        // 3: three-beat write with a stall on the second cycle
        run_write(12'h020, 4'd2, 16'hB0B0, 8'b0000_1101, 4);
        run_read(12'h020, 4'd2);
        // 4: wrapping read
        preload(12'hFFE, 16'hC0C0);
        preload(12'hFFF, 16'hC1C1);
        preload(12'h000, 16'hC2C2);
        preload(12'h001, 16'hC3C3);
        run_read(12'hFFE, 4'd3);
        // single-beat read
        run_read(12'h012, 4'd0);

        // 5: reset during read beat 2
        send_req(1'b0, 12'h010, 4'd3);
        cycle();
        cycle();
        chk("abort_pre_ce", 32'(mem_ce), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_ce", 32'(mem_ce), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_ce", 32'(mem_ce), 32'd0);
            chk("post_rst_ready", 32'(req_ready), 32'd1);
            cycle();
        end
        run_read(12'h010, 4'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
